// File: rtl/mcl_pkg.sv
// rtl/mcl_pkg.sv - shared types for the MBOX request queue
package mcl_pkg;

    typedef enum logic [3:0] {
        MF_NOP        = 4'd0,
        MF_RSVD1      = 4'd1,
        MF_MB_WAIT    = 4'd2,
        MF_RESTORE    = 4'd3,
        MF_AREAD      = 4'd4,
        MF_B_WRITE    = 4'd5,
        MF_COND_FETCH = 4'd6,
        MF_REG_FUNC   = 4'd7,
        MF_AD_FUNC    = 4'd8,
        MF_EA_CALC    = 4'd9,
        MF_LOAD_AR    = 4'd10,
        MF_LOAD_ARX   = 4'd11,
        MF_RW         = 4'd12,
        MF_RPW        = 4'd13,
        MF_WRITE      = 4'd14,
        MF_FETCH      = 4'd15
    } mem_func_e;

    typedef enum logic [1:0] {
        PF_NONE    = 2'b00,
        PF_ADR_ERR = 2'b01,
        PF_BREAK   = 2'b10
    } pf_code_e;

    // Flag half of an MBOX descriptor; the full bus is {mbox_desc_t, va}.
    typedef struct packed {
        logic load_ar;
        logic load_arx;
        logic pause;
        logic write;
        logic fetch;
        logic user;
        logic public;
        logic previous;
        logic extended;
    } mbox_desc_t;

endpackage

// File: rtl/mcl_req_queue_if.sv
// rtl/mcl_req_queue_if.sv - MBOX request/acknowledge port
interface mcl_req_queue_if #(
    parameter int VA_W = 23
);
    logic            mbox_req;
    logic            mbox_ack;
    logic [VA_W+8:0] mbox_desc;

    modport master (output mbox_req, output mbox_desc, input mbox_ack);
    modport slave  (input mbox_req, input mbox_desc, output mbox_ack);
endinterface

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - small FIFO with flush, head-of-queue output and occupancy
module req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Explicit wrap so non-power-of-two depths also index correctly.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/mcl_req_queue.sv
// rtl/mcl_req_queue.sv - CRAM MEM decode, fault detection and MBOX request queue
module mcl_req_queue
    import mcl_pkg::*;
#(
    parameter int VA_W   = 23,
    parameter int SECT_W = 5,
    parameter int NSECT  = 32,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [3:0]                  mem_func,
    input  logic [0:8]                  magic,
    input  logic [0:7]                  ad_ctl,
    input  logic [VA_W-1:0]             va,
    input  logic                        user,
    input  logic                        public,
    input  logic                        prev_en,
    input  logic                        extend,
    input  logic                        test_satisfied,
    input  logic                        pi_cycle,
    input  logic [2:0]                  brk_en,
    input  logic [VA_W-1:0]             brk_addr,
    input  logic                        pf_clr,
    input  logic                        flush,
    mcl_req_queue_if.master             mbox,
    output logic                        ebox_stall,
    output logic                        skip_satisfied,
    output logic                        page_fail,
    output logic [1:0]                  pf_code,
    output logic [VA_W+8:0]             held_desc,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int CW = $clog2(DEPTH+1);

    mem_func_e  func;
    mbox_desc_t flags;
    logic [3:0] ext_ops;
    logic       cond_fetch;
    logic       mem_cycle;
    logic       rd_cycle;
    logic       adr_err;
    logic       brk_hit;
    logic       fault;
    logic       accept;
    logic       push;
    logic       pop;
    logic [31:0] sect_num;
    pf_code_e   pf_q;
    logic       unused_magic;

    assign func         = mem_func_e'(mem_func);
    assign cond_fetch   = (func == MF_COND_FETCH) & test_satisfied & ~pi_cycle;
    assign unused_magic = ^{magic[4], magic[6:8]};

    // EA_CALC and AD_FUNC/RESTORE supply {load_ar, load_arx, pause, write} directly.
    always_comb begin
        ext_ops = 4'b0000;
        if (func == MF_EA_CALC)
            ext_ops = magic[0:3];
        else if (func == MF_AD_FUNC || func == MF_RESTORE)
            ext_ops = ad_ctl[4:7];
    end

    always_comb begin
        flags.load_ar  = ext_ops[3] | (func == MF_LOAD_AR) | (func == MF_RW) | (func == MF_RPW);
        flags.load_arx = ext_ops[2] | (func == MF_LOAD_ARX) | (func == MF_FETCH) | cond_fetch;
        flags.pause    = ext_ops[1] | (func == MF_RPW);
        flags.write    = ext_ops[0] | (func == MF_WRITE) | (func == MF_RW) | (func == MF_RPW)
                       | (func == MF_B_WRITE);
        flags.fetch    = (func == MF_FETCH) | cond_fetch;
        if (func == MF_AD_FUNC || func == MF_RESTORE)
            {flags.user, flags.public, flags.previous, flags.extended} = ad_ctl[0:3];
        else
            {flags.user, flags.public, flags.previous, flags.extended} = {user, public, prev_en, extend};
    end

    assign mem_cycle = flags.load_ar | flags.load_arx | flags.pause | flags.write | flags.fetch;
    assign rd_cycle  = (flags.load_ar | flags.load_arx) & ~flags.fetch;

    // Section field is only meaningful in extended addressing.
    assign sect_num = 32'(va[VA_W-1 -: SECT_W]);
    assign adr_err  = extend & (sect_num >= 32'(NSECT));
    assign brk_hit  = ((flags.fetch & brk_en[2]) | (rd_cycle & brk_en[1]) | (flags.write & brk_en[0]))
                    & (va == brk_addr);
    assign fault    = mem_cycle & (adr_err | brk_hit);

    assign accept = mem_cycle & ~fault & ((count != CW'(DEPTH)) | mbox.mbox_ack);
    assign push   = accept & ~flush;
    assign pop    = mbox.mbox_req & mbox.mbox_ack & ~flush;

    assign ebox_stall = ~flush & ((mem_cycle & ~fault & ~accept)
                               | ((func == MF_MB_WAIT) & (count != '0)));
    assign skip_satisfied = (func == MF_COND_FETCH) & magic[5] & test_satisfied;
    assign mbox.mbox_req  = (count != '0);
    assign pf_code        = pf_q;

    req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (VA_W + 9)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({flags, va}),
        .pop       (pop),
        .flush     (flush),
        .head      (mbox.mbox_desc),
        .count     (count)
    );

    // First fault's code sticks; a clear coinciding with a new fault yields the new code.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            page_fail <= 1'b0;
            pf_q      <= PF_NONE;
            held_desc <= '0;
        end else begin
            if (fault) begin
                page_fail <= 1'b1;
                if (pf_clr || pf_q == PF_NONE)
                    pf_q <= adr_err ? PF_ADR_ERR : PF_BREAK;
            end else if (pf_clr) begin
                page_fail <= 1'b0;
                pf_q      <= PF_NONE;
            end
            if (pop) held_desc <= mbox.mbox_desc;
        end
    end
endmodule

// File: tb/tb_mcl_req_queue.sv
// tb/tb_mcl_req_queue.sv - self-checking bench for mcl_req_queue
module tb_mcl_req_queue;
    localparam int VA_W = 23, SECT_W = 6, NSECT = 32, DEPTH = 2, DW = VA_W + 9;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] mem_func;
    logic [0:8] magic;
    logic [0:7] ad_ctl;
    logic [VA_W-1:0] va, brk_addr;
    logic user, public, prev_en, extend, test_satisfied, pi_cycle, pf_clr, flush;
    logic [2:0] brk_en;
    logic ebox_stall, skip_satisfied, page_fail;
    logic [1:0] pf_code;
    logic [DW-1:0] held_desc;
    logic [1:0] count;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_held;
    logic m_pf;
    logic [1:0] m_code;

    mcl_req_queue_if #(.VA_W(VA_W)) mbox_if();

    mcl_req_queue #(.VA_W(VA_W), .SECT_W(SECT_W), .NSECT(NSECT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .mem_func(mem_func), .magic(magic), .ad_ctl(ad_ctl),
        .va(va), .user(user), .public(public), .prev_en(prev_en), .extend(extend),
        .test_satisfied(test_satisfied), .pi_cycle(pi_cycle), .brk_en(brk_en),
        .brk_addr(brk_addr), .pf_clr(pf_clr), .flush(flush), .mbox(mbox_if),
        .ebox_stall(ebox_stall), .skip_satisfied(skip_satisfied), .page_fail(page_fail),
        .pf_code(pf_code), .held_desc(held_desc), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk_desc(input bit lar, larx, pau, wr, fe,
                                              input logic [3:0] ctx, input logic [VA_W-1:0] a);
        return {lar, larx, pau, wr, fe, ctx, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_func = 4'd0; magic = '0; ad_ctl = '0; va = '0;
        user = 0; public = 0; prev_en = 0; extend = 0;
        test_satisfied = 0; pi_cycle = 0; brk_en = 3'b000; brk_addr = '0;
        pf_clr = 0; flush = 0; mbox_if.mbox_ack = 0;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        repeat (2) tick();
        n_checks++; if (mbox_if.mbox_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", mbox_if.mbox_req); end
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (page_fail !== 1'b0 || pf_code !== 2'b00) begin n_fail++; $display("FAIL reset_pf got %b/%b exp 0/00", page_fail, pf_code); end
        n_checks++; if (held_desc !== '0 || ebox_stall !== 1'b0) begin n_fail++; $display("FAIL reset_held got %h/%b exp 0/0", held_desc, ebox_stall); end
        reset_n = 1;
        tick();
    endtask

    task automatic test_rw();
        logic [DW-1:0] d;
        idle();
        mem_func = 4'd12; va = 23'o1234;
        d = mk_desc(1, 0, 0, 1, 0, 4'b0000, 23'o1234);
        @(negedge clk);
        n_checks++; if (mbox_if.mbox_req !== 1'b0 || ebox_stall !== 1'b0) begin n_fail++; $display("FAIL rw_pre got req=%b stall=%b exp 0/0", mbox_if.mbox_req, ebox_stall); end
        tick();
        mem_func = 4'd0;
        n_checks++; if (mbox_if.mbox_req !== 1'b1) begin n_fail++; $display("FAIL rw_req got %b exp 1", mbox_if.mbox_req); end
        n_checks++; if (mbox_if.mbox_desc !== d) begin n_fail++; $display("FAIL rw_desc got %h exp %h", mbox_if.mbox_desc, d); end
        mbox_if.mbox_ack = 1;
        tick();
        mbox_if.mbox_ack = 0;
        n_checks++; if (held_desc !== d) begin n_fail++; $display("FAIL rw_held got %h exp %h", held_desc, d); end
        n_checks++; if (count !== 2'd0 || mbox_if.mbox_req !== 1'b0) begin n_fail++; $display("FAIL rw_drain got count=%0d req=%b exp 0/0", count, mbox_if.mbox_req); end
    endtask

    task automatic test_full_stall();
        idle();
        mem_func = 4'd13; va = 23'd100;
        tick();
        va = 23'd101;
        tick();
        va = 23'd102;
        @(negedge clk);
        n_checks++; if (ebox_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got %b exp 1", ebox_stall); end
        tick();
        n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL full_count got %0d exp 2", count); end
        mbox_if.mbox_ack = 1;
        @(negedge clk);
        n_checks++; if (ebox_stall !== 1'b0) begin n_fail++; $display("FAIL full_ack_stall got %b exp 0", ebox_stall); end
        tick();
        n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL full_swap_count got %0d exp 2", count); end
        n_checks++; if (held_desc !== mk_desc(1, 0, 1, 1, 0, 4'b0, 23'd100)) begin n_fail++; $display("FAIL full_held got %h exp %h", held_desc, mk_desc(1, 0, 1, 1, 0, 4'b0, 23'd100)); end
        n_checks++; if (mbox_if.mbox_desc !== mk_desc(1, 0, 1, 1, 0, 4'b0, 23'd101)) begin n_fail++; $display("FAIL full_head got %h exp %h", mbox_if.mbox_desc, mk_desc(1, 0, 1, 1, 0, 4'b0, 23'd101)); end
        mem_func = 4'd0;
        tick();
        tick();
        mbox_if.mbox_ack = 0;
        n_checks++; if (count !== 2'd0 || held_desc !== mk_desc(1, 0, 1, 1, 0, 4'b0, 23'd102)) begin n_fail++; $display("FAIL full_drain got count=%0d held=%h exp 0/%h", count, held_desc, mk_desc(1, 0, 1, 1, 0, 4'b0, 23'd102)); end
    endtask

    task automatic test_adr_err();
        idle();
        extend = 1; va = {6'o40, 17'd5}; mem_func = 4'd10;
        @(negedge clk);
        n_checks++; if (ebox_stall !== 1'b0) begin n_fail++; $display("FAIL aerr_stall got %b exp 0", ebox_stall); end
        tick();
        n_checks++; if (page_fail !== 1'b1 || pf_code !== 2'b01 || count !== 2'd0) begin n_fail++; $display("FAIL aerr_flag got pf=%b code=%b count=%0d exp 1/01/0", page_fail, pf_code, count); end
        extend = 0; mem_func = 4'd15; va = 23'o777; brk_addr = 23'o777; brk_en = 3'b100;
        tick();
        n_checks++; if (page_fail !== 1'b1 || pf_code !== 2'b01 || count !== 2'd0) begin n_fail++; $display("FAIL aerr_keep got pf=%b code=%b count=%0d exp 1/01/0", page_fail, pf_code, count); end
        mem_func = 4'd0; brk_en = 3'b000; pf_clr = 1;
        tick();
        n_checks++; if (page_fail !== 1'b0 || pf_code !== 2'b00) begin n_fail++; $display("FAIL aerr_clr got %b/%b exp 0/00", page_fail, pf_code); end
        mem_func = 4'd14; va = brk_addr; brk_en = 3'b001;
        tick();
        n_checks++; if (page_fail !== 1'b1 || pf_code !== 2'b10 || count !== 2'd0) begin n_fail++; $display("FAIL brk_over_clr got pf=%b code=%b count=%0d exp 1/10/0", page_fail, pf_code, count); end
        mem_func = 4'd0; brk_en = 3'b000;
        tick();
        pf_clr = 0;
        mem_func = 4'd10; va = {6'o77, 17'd3};
        tick();
        mem_func = 4'd0;
        n_checks++; if (page_fail !== 1'b0 || count !== 2'd1) begin n_fail++; $display("FAIL sect_ignored got pf=%b count=%0d exp 0/1", page_fail, count); end
        mbox_if.mbox_ack = 1;
        tick();
        mbox_if.mbox_ack = 0;
    endtask

    task automatic test_cond_fetch();
        idle();
        mem_func = 4'd6; test_satisfied = 1; pi_cycle = 0; magic[5] = 1'b1; user = 1; va = 23'o4321;
        @(negedge clk);
        n_checks++; if (skip_satisfied !== 1'b1 || ebox_stall !== 1'b0) begin n_fail++; $display("FAIL cf_skip got skip=%b stall=%b exp 1/0", skip_satisfied, ebox_stall); end
        tick();
        mem_func = 4'd0;
        n_checks++; if (count !== 2'd1 || mbox_if.mbox_desc !== mk_desc(0, 1, 0, 0, 1, 4'b1000, 23'o4321)) begin n_fail++; $display("FAIL cf_desc got count=%0d desc=%h exp 1/%h", count, mbox_if.mbox_desc, mk_desc(0, 1, 0, 0, 1, 4'b1000, 23'o4321)); end
        mbox_if.mbox_ack = 1;
        tick();
        mbox_if.mbox_ack = 0;
        mem_func = 4'd6; pi_cycle = 1;
        @(negedge clk);
        n_checks++; if (skip_satisfied !== 1'b1 || ebox_stall !== 1'b0) begin n_fail++; $display("FAIL cf_pi_skip got skip=%b stall=%b exp 1/0", skip_satisfied, ebox_stall); end
        tick();
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL cf_pi_count got %0d exp 0", count); end
    endtask

    task automatic test_mb_wait_flush();
        idle();
        mem_func = 4'd15; va = 23'd7;
        tick();
        mem_func = 4'd2;
        @(negedge clk);
        n_checks++; if (ebox_stall !== 1'b1) begin n_fail++; $display("FAIL mbw_stall1 got %b exp 1", ebox_stall); end
        tick();
        mbox_if.mbox_ack = 1;
        @(negedge clk);
        n_checks++; if (ebox_stall !== 1'b1) begin n_fail++; $display("FAIL mbw_stall2 got %b exp 1", ebox_stall); end
        tick();
        mbox_if.mbox_ack = 0;
        @(negedge clk);
        n_checks++; if (ebox_stall !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL mbw_release got stall=%b count=%0d exp 0/0", ebox_stall, count); end
        tick();
        mem_func = 4'd15; va = 23'd8;
        tick();
        mem_func = 4'd12; va = 23'd9; flush = 1;
        @(negedge clk);
        n_checks++; if (ebox_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", ebox_stall); end
        tick();
        flush = 0; mem_func = 4'd0;
        n_checks++; if (count !== 2'd0 || mbox_if.mbox_req !== 1'b0) begin n_fail++; $display("FAIL flush_count got count=%0d req=%b exp 0/0", count, mbox_if.mbox_req); end
        n_checks++; if (held_desc !== mk_desc(0, 1, 0, 0, 1, 4'b0, 23'd7)) begin n_fail++; $display("FAIL flush_held got %h exp %h", held_desc, mk_desc(0, 1, 0, 0, 1, 4'b0, 23'd7)); end
    endtask

    task automatic test_reset_mid();
        idle();
        mem_func = 4'd14; va = 23'd1;
        tick();
        va = 23'd2;
        tick();
        extend = 1; va = {6'o50, 17'd0};
        tick();
        idle();
        n_checks++; if (count !== 2'd2 || page_fail !== 1'b1) begin n_fail++; $display("FAIL mid_pre got count=%0d pf=%b exp 2/1", count, page_fail); end
        #2 reset_n = 0;
        #1;
        n_checks++; if (count !== 2'd0 || mbox_if.mbox_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_q got count=%0d req=%b exp 0/0", count, mbox_if.mbox_req); end
        n_checks++; if (page_fail !== 1'b0 || pf_code !== 2'b00 || held_desc !== '0) begin n_fail++; $display("FAIL mid_rst_pf got pf=%b code=%b held=%h exp 0/00/0", page_fail, pf_code, held_desc); end
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    task automatic test_random();
        logic [4:0] ops;
        logic [3:0] ctx;
        bit mem, rd, brk, aerr, flt, acc, e_stall, e_skip;
        mq.delete(); m_held = '0; m_pf = 0; m_code = 2'b00;
        idle();
        brk_addr = VA_W'($urandom());
        for (int i = 0; i < 600; i++) begin
            mem_func = 4'($urandom_range(0, 15));
            magic = 9'($urandom()); ad_ctl = 8'($urandom());
            user = 1'($urandom()); public = 1'($urandom()); prev_en = 1'($urandom());
            extend = ($urandom_range(0, 3) == 0);
            va = ($urandom_range(0, 3) == 0) ? brk_addr : VA_W'($urandom());
            test_satisfied = 1'($urandom()); pi_cycle = 1'($urandom());
            brk_en = ($urandom_range(0, 3) == 0) ? 3'($urandom()) : 3'b000;
            pf_clr = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 19) == 0);
            mbox_if.mbox_ack = 1'($urandom());

            ctx = {user, public, prev_en, extend};
            case (mem_func)
                4'd3, 4'd8: begin ops = {ad_ctl[4:7], 1'b0}; ctx = ad_ctl[0:3]; end
                4'd9:       ops = {magic[0:3], 1'b0};
                4'd5, 4'd14: ops = 5'b00010;
                4'd6:       ops = (test_satisfied && !pi_cycle) ? 5'b01001 : 5'b00000;
                4'd10:      ops = 5'b10000;
                4'd11:      ops = 5'b01000;
                4'd12:      ops = 5'b10010;
                4'd13:      ops = 5'b10110;
                4'd15:      ops = 5'b01001;
                default:    ops = 5'b00000;
            endcase
            mem = (ops != 0);
            rd = (ops[4] || ops[3]) && !ops[0];
            brk = (va == brk_addr) && ((ops[0] && brk_en[2]) || (rd && brk_en[1]) || (ops[1] && brk_en[0]));
            aerr = extend && ((va >> (VA_W - SECT_W)) >= NSECT);
            flt = mem && (aerr || brk);
            acc = mem && !flt && (mq.size() < DEPTH || mbox_if.mbox_ack);
            e_stall = !flush && ((mem && !flt && !acc) || (mem_func == 4'd2 && mq.size() != 0));
            e_skip = (mem_func == 4'd6) && magic[5] && test_satisfied;

            @(negedge clk);
            n_checks++; if (ebox_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall[%0d] got %b exp %b", i, ebox_stall, e_stall); end
            n_checks++; if (skip_satisfied !== e_skip) begin n_fail++; $display("FAIL rnd_skip[%0d] got %b exp %b", i, skip_satisfied, e_skip); end
            n_checks++; if (mbox_if.mbox_req !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_req[%0d] got %b exp %b", i, mbox_if.mbox_req, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_checks++; if (mbox_if.mbox_desc !== mq[0]) begin n_fail++; $display("FAIL rnd_head[%0d] got %h exp %h", i, mbox_if.mbox_desc, mq[0]); end
            end

            if (flush) mq.delete();
            else begin
                if (mbox_if.mbox_ack && mq.size() != 0) m_held = mq.pop_front();
                if (acc) mq.push_back({ops, ctx, va});
            end
            if (flt) begin
                m_pf = 1;
                if (pf_clr || m_code == 2'b00) m_code = aerr ? 2'b01 : 2'b10;
            end else if (pf_clr) begin
                m_pf = 0; m_code = 2'b00;
            end

            tick();
            n_checks++; if (page_fail !== m_pf || pf_code !== m_code) begin n_fail++; $display("FAIL rnd_pf[%0d] got %b/%b exp %b/%b", i, page_fail, pf_code, m_pf, m_code); end
            n_checks++; if (held_desc !== m_held) begin n_fail++; $display("FAIL rnd_held[%0d] got %h exp %h", i, held_desc, m_held); end
            n_checks++; if (count !== 2'(mq.size())) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, count, mq.size()); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_rw();
        test_full_stall();
        test_adr_err();
        test_cond_fetch();
        test_mb_wait_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mcl_req_queue.md
Name: mcl_req_queue

Overview:
- Parametrised successor to the EBOX memory-control decode: decodes the 4-bit CRAM MEM field into MBOX cycle descriptors and queues up to DEPTH outstanding requests instead of one.
- Adds a req/ack handshake to MBOX, address-break compare, section-range address-error detection, a sticky page-fail flag and a held-descriptor register for page-fail reporting.
- Sits between CRAM/EDP/SCD sources and the MBOX request port.

Parameters:
- VA_W, 23, virtual address width (section + in-section address).
- SECT_W, 5, section-number field width; top SECT_W bits of va.
- NSECT, 32, legal section count; sections >= NSECT give an address error.
- DEPTH, 2, request queue entries (power of two, >= 1).

Ports:
- clk  in  1  EBOX memory-control clock.
- reset_n  in  1  asynchronous active-low reset.
- mem_func  in  4  CRAM MEM field.
- magic  in  9  CRAM MAGIC[0:8].
- ad_ctl  in  8  EDP AD[5:12] context bits, used by AD_FUNC and RESTORE.
- va  in  VA_W  address for this cycle.
- user, public, prev_en, extend  in  1 each  context inputs from SCD/APR.
- test_satisfied, pi_cycle  in  1 each  condition inputs.
- brk_en  in  3  address-break enable {fetch, read, write}.
- brk_addr  in  VA_W  address-break compare value.
- pf_clr, flush  in  1 each  clear page-fail; drop all queued entries.
- mbox_req  out  1  head entry valid.
- mbox_ack  in  1  MBOX accepts the head entry.
- mbox_desc  out  9+VA_W  head: {load_ar, load_arx, pause, write, fetch, user, public, previous, extended, va}.
- ebox_stall  out  1  issuing cycle not accepted; EBOX must hold mem_func.
- skip_satisfied  out  1  conditional-fetch skip.
- page_fail  out  1  sticky fault flag.
- pf_code  out  2  00 none, 01 adr_err, 10 addr break.
- held_desc  out  9+VA_W  last descriptor accepted by MBOX.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset values: mbox_req=0, ebox_stall=0, page_fail=0, pf_code=0, held_desc=0, count=0; queue pointers = 0. Async assert; synchronous deassert is the caller's job.
- Decode, combinational:
  - 0 NOP; 2 MB_WAIT; 3 RESTORE; 4 AREAD; 5 B_WRITE; 6 COND_FETCH; 7 REG_FUNC.
  - 8 AD_FUNC; 9 EA_CALC; 10 LOAD_AR; 11 LOAD_ARX; 12 RW; 13 RPW; 14 WRITE; 15 FETCH.
  - Codes 1 and 7 are accepted and enqueue nothing.
- Descriptor bits:
  - load_ar = LOAD_AR | RW | RPW.
  - load_arx = LOAD_ARX | FETCH | (COND_FETCH & test_satisfied & ~pi_cycle).
  - pause = RPW.
  - write = WRITE | RW | RPW | B_WRITE.
  - fetch = same condition as load_arx.
  - EA_CALC takes the four ops from magic[0:3].
  - AD_FUNC/RESTORE take the ops from ad_ctl and the context from ad_ctl[0:3]; otherwise context = {user, public, prev_en, extend}.
  - A cycle is a memory cycle iff any op bit is set.
- skip_satisfied = COND_FETCH & magic[5] & test_satisfied.
- Address error: extend=1 and va section >= NSECT; section ignored when extend=0.
- Address break: (fetch&brk_en[2] | read&brk_en[1] | write&brk_en[0]) & va==brk_addr, where read = load_ar|load_arx with fetch=0.
- Fault on a memory cycle:
  - no enqueue; page_fail<=1 next edge.
  - pf_code = 01 for adr_err (priority), otherwise 10.
  - Further faults do not overwrite the code; pf_clr clears both.
  - pf_clr in the same cycle as a new fault: fault wins.
- Accept = memory cycle & no fault & (count<DEPTH | mbox_ack).
  - ebox_stall = memory cycle & no fault & ~accept.
  - MB_WAIT: ebox_stall = (count!=0).
- Queue FIFO:
  - mbox_req = count!=0; mbox_desc = head entry.
  - On mbox_req&mbox_ack: head pops and held_desc <= head.
  - Enqueue and dequeue in one cycle leave count unchanged, including at full.
  - Pointers wrap modulo DEPTH. Ack with empty queue is ignored.
- flush: count<=0 and pointers<=0 next edge; a same-cycle enqueue is dropped, ebox_stall=0, held_desc kept, page_fail unaffected.
- Latency: request accepted at edge N shows mbox_req at N+1 when the queue was empty.

Decomposition:
- Package mcl_pkg: mem_func enum with the codes above, mbox_desc_t packed struct, pf_code enum.
- Sub-module req_fifo (DEPTH, width, push/pop/flush/count) instantiated once.

Test Plan:
- Reset mid-traffic: 2 entries queued, reset_n low -> count=0, mbox_req=0, page_fail=0 immediately.
- mem_func=12 va=0o1234, no ack -> mbox_req=1 next cycle, desc load_ar=1 write=1 pause=0. Ack -> held_desc equals that desc, count=0.
- DEPTH=2: three RPW cycles with no ack -> third gives ebox_stall=1. Third repeated with mbox_ack=1 -> accepted, count stays 2.
- extend=1, section=0o40, NSECT=32, mem_func=10 -> no enqueue, page_fail=1, pf_code=01. Break match in the next cycle -> pf_code stays 01. pf_clr -> 0/00.
- COND_FETCH, test_satisfied=1, pi_cycle=0, magic[5]=1 -> skip_satisfied=1, fetch desc queued. Same with pi_cycle=1 -> nothing queued, no stall.
- MB_WAIT with count=1 -> ebox_stall=1 until ack, then 0. Flush with enqueue pending -> count=0 next cycle.
